button_conditioner: RTL

Input-conditioning stage for the push-button counter path. It takes a raw mechanical button and turns it into a clean one-cycle count pulse on the system clock, with optional auto-repeat while the button is held. It replaces a divided-clock debouncer: everything runs on one clock, and the downstream counter consumes `pulse` as a clock enable.

---
 rtl/button_conditioner.sv | 122 ++++++++++++
 1 files changed

// File: rtl/button_conditioner.sv
// Push-button conditioner: two-flop synchronizer, counter-based debounce FSM,
// and optional auto-repeat, producing a one-cycle count strobe and a clean level.
module button_conditioner #(
   parameter int STABLE_CYCLES = 500000,
   parameter int REPEAT_DELAY  = 25000000,
   parameter int REPEAT_PERIOD = 10000000,
   parameter int CNT_W         = 25
) (
   input  logic clk,
   input  logic reset,
   input  logic button,
   input  logic repeat_en,
   output logic pulse,
   output logic level
);

   typedef enum logic [1:0] {
      IDLE,
      PRESS_CHK,
      HELD,
      RELEASE_CHK
   } state_t;

   localparam logic [CNT_W-1:0] STABLE_LIM = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] DELAY_LIM  = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] PERIOD_LIM = CNT_W'(REPEAT_PERIOD - 1);

   logic             ff1_q, ff2_q;
   logic             sync;
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] rpt_q, rpt_d;
   logic [CNT_W-1:0] rpt_lim;
   logic             first_q, first_d;
   logic             pulse_q, pulse_d;
   logic             level_q, level_d;

   assign sync    = ff2_q;
   assign rpt_lim = first_q ? DELAY_LIM : PERIOD_LIM;
   assign pulse   = pulse_q;
   assign level   = level_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         ff1_q   <= 1'b0;
         ff2_q   <= 1'b0;
         state_q <= IDLE;
         cnt_q   <= '0;
         rpt_q   <= '0;
         first_q <= 1'b1;
         pulse_q <= 1'b0;
         level_q <= 1'b0;
      end else begin
         ff1_q   <= button;
         ff2_q   <= ff1_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rpt_q   <= rpt_d;
         first_q <= first_d;
         pulse_q <= pulse_d;
         level_q <= level_d;
      end
   end

   // Counters compare against their limit before incrementing, so they never wrap.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rpt_d   = rpt_q;
      first_d = first_q;
      pulse_d = 1'b0;
      level_d = level_q;
      case (state_q)
         IDLE: begin
            if (sync) begin
               state_d = PRESS_CHK;
               cnt_d   = '0;
            end
         end
         PRESS_CHK: begin
            if (!sync) begin
               state_d = IDLE;
            end else if (cnt_q == STABLE_LIM) begin
               state_d = HELD;
               pulse_d = 1'b1;
               level_d = 1'b1;
               rpt_d   = '0;
               first_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         HELD: begin
            if (!sync) begin
               state_d = RELEASE_CHK;
               cnt_d   = '0;
            end else if (repeat_en) begin
               if (rpt_q == rpt_lim) begin
                  pulse_d = 1'b1;
                  rpt_d   = '0;
                  first_d = 1'b0;
               end else begin
                  rpt_d = rpt_q + CNT_W'(1);
               end
            end
         end
         RELEASE_CHK: begin
            // A bounce back to 1 resumes HELD with the repeat progress intact.
            if (sync) begin
               state_d = HELD;
            end else if (cnt_q == STABLE_LIM) begin
               state_d = IDLE;
               level_d = 1'b0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule
